crop_serializer: RTL and testbench
==================================

// Module: crop_serializer
// PURPOSE
//  Parametrised successor to the 1-lane burst serializer. Accepts IN_LANES pixels per input beat and emits
//  OUT_LANES pixels per output beat, forwarding only pixels inside an OUT_COLS x OUT_ROWS crop window.
//  Adds SOF/EOL/EOF markers, full-throughput ping-pong buffering and mid-frame SOF recovery.
//  Sits between the CXP pixel-stream unpacker and the downstream ROI processing pipeline.
// PARAMETERS
//  PIXEL_BIT_WIDTH  10   bits per pixel
//  IN_LANES         10   pixels per input beat; IN_COLS % IN_LANES == 0
//  OUT_LANES        2    pixels per output beat; IN_LANES % OUT_LANES == 0; RATIO = IN_LANES/OUT_LANES
//  USER_WIDTH       2    input tuser width; only bit 0 (SOF) is used
//  IN_ROWS/IN_COLS  20/20  input frame size, in pixels
//  OUT_ROWS/OUT_COLS 10/10 crop size; OUT_COLS % OUT_LANES == 0
// PORTS
//  clk            in   1                     clock
//  reset          in   1                     asynchronous, active-high reset
//  s_axis_tvalid  in   1                     input beat valid
//  s_axis_tready  out  1                     input beat ready
//  s_axis_tdata   in   PIXEL_BIT_WIDTH*IN_LANES   pixels; lane 0 = lowest column
//  s_axis_tuser   in   USER_WIDTH            bit0 = SOF on the first beat of a frame
//  crop_x0        in   $clog2(IN_COLS)       crop left column; sampled on SOF accept
//  crop_y0        in   $clog2(IN_ROWS)       crop top row; sampled on SOF accept
//  m_axis_tvalid  out  1                     output valid
//  m_axis_tready  in   1                     output ready
//  m_axis_tdata   out  PIXEL_BIT_WIDTH*OUT_LANES  cropped pixels; lane 0 = lowest column
//  m_axis_tuser   out  2                     bit0 = SOF (first crop beat), bit1 = EOF (last crop beat)
//  m_axis_tlast   out  1                     last beat of a crop row (EOL)
//  err_count      out  16                    aborted-frame count (SEQ_ERR_CNT_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: FSM=IDLE, both buffers empty, counters 0, m_axis_tvalid=0, tdata/tuser/tlast=0.
//    s_axis_tready=0 while reset is asserted.
//  - Window clamping: x0c = min(crop_x0 & ~(OUT_LANES-1), IN_COLS-OUT_COLS);
//    y0c = min(crop_y0, IN_ROWS-OUT_ROWS). Both are latched on the SOF handshake.
//  - FSM
//    - IDLE: s_axis_tready=1. Non-SOF beats are discarded. An SOF handshake loads buffer A,
//      resets the row/col counters, then -> RUN.
//    - RUN: two beat buffers (ping-pong) plus a sub-beat index 0..RATIO-1.
//      - s_axis_tready=1 while any buffer is free.
//      - Each sub-beat at column c and row r is "kept" when x0c<=c<x0c+OUT_COLS and y0c<=r<y0c+OUT_ROWS.
//      - Kept sub-beats are presented with m_axis_tvalid=1 and advance only on the m handshake.
//      - Discarded sub-beats advance one per clk without asserting tvalid. Whole beats entirely outside
//        the window are skipped in 1 clk.
//      - The last input beat of the frame (row IN_ROWS-1, last column beat) fully consumed -> IDLE.
//  - Latency: input handshake to first m_axis_tvalid = 1 clk when the window starts in that beat.
//    Sustained output is 1 beat/clk while m_axis_tready=1; no bubbles across input-beat boundaries.
//  - Markers
//    - tlast=1 on the kept sub-beat whose columns end at x0c+OUT_COLS-1.
//    - tuser[0]=1 on the first kept sub-beat of the frame.
//    - tuser[1]=1 on the final kept sub-beat (row y0c+OUT_ROWS-1 and tlast).
//  - Holding: tdata/tuser/tlast remain stable while tvalid=1 and tready=0 (AXI-S rule).
//  - SOF while in RUN (truncated frame): both buffers are flushed, any pending output is dropped
//    (tvalid deasserted next clk, no EOF emitted), the new SOF beat is loaded, counters restart,
//    and the state stays RUN.
//  - A simultaneous buffer free and input accept in the same clk is legal, with no lost beat.
//  - Counters: col counter wraps at IN_COLS/IN_LANES-1 and increments the row counter; the row counter
//    wraps at IN_ROWS-1. All compares are unsigned at full counter width.
//  - Async reset mid-frame: returns to the reset state immediately; the next frame requires an SOF.
// CONFIGURATION
//  - SEQ_ERR_CNT_EN defined:
//    - err_count increments, saturating at 16'hFFFF, on every mid-frame SOF abort.
//    - The frame-end check also counts input beats with tuser[0]=0 arriving in IDLE.
//    - Cleared only by reset.
//  - SEQ_ERR_CNT_EN undefined: err_count tied to 0; no counter logic is synthesised.
// TESTING
//  - Full-window default: 20x20 ramp frame (pixel = row*20+col), crop 0,0, OUT 10x10, tready=1.
//    -> 50 beats out, with pixels 0..9,20..29,..; tlast every 5th beat; tuser[0] on beat 0, tuser[1] on beat 49.
//  - Offset crop x0=7,y0=3: x0 is aligned to 6.
//    -> first beat {67,66}, last beat {255,254}, exactly 50 beats.
//  - Clamp: crop x0=19, y0=19 -> window 10..19 x 10..19; first beat {211,210}.
//  - Backpressure: tready toggles 1010 and tvalid input is random.
//    -> output sequence identical to the tready=1 case; tdata is stable whenever tvalid&&!tready.
//  - Abort: SOF re-asserted at input beat 17 of frame 1.
//    -> no tuser[1] is emitted for frame 1; frame 2 output is correct; err_count=1 if SEQ_ERR_CNT_EN.
//  - Async reset mid-output: reset asserted at beat 20.
//    -> tvalid=0 in the same clk; stray non-SOF beats are dropped; the next SOF frame is correct.

Source files
------------

// File: rtl/crop_serializer.sv
// rtl/crop_serializer.sv - crop-window pixel serializer with ping-pong beat buffers
// Purpose: accepts IN_LANES-pixel beats and forwards only the pixels inside an
//   OUT_COLS x OUT_ROWS crop window as OUT_LANES-pixel beats. It also adds SOF/EOL/EOF
//   markers and restarts cleanly when an SOF arrives mid-frame.
// Optional feature macro: SEQ_ERR_CNT_EN (aborted-frame / stray-beat counter on err_count).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   s_axis_*              input beats; tuser[0] = SOF; lane 0 = lowest column
//   crop_x0, crop_y0      crop origin, latched on the SOF handshake
//   m_axis_*              output beats; tuser = {EOF, SOF}; tlast = end of crop row
//   err_count             sequence error count (0 unless SEQ_ERR_CNT_EN)
module crop_serializer #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int IN_LANES        = 10,
  parameter int OUT_LANES       = 2,
  parameter int USER_WIDTH      = 2,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH*IN_LANES-1:0]  s_axis_tdata,
  input  logic [USER_WIDTH-1:0]                s_axis_tuser,
  input  logic [$clog2(IN_COLS)-1:0]           crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0]           crop_y0,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [PIXEL_BIT_WIDTH*OUT_LANES-1:0] m_axis_tdata,
  output logic [1:0]                           m_axis_tuser,
  output logic                                 m_axis_tlast,
  output logic [15:0]                          err_count
);
  localparam int RATIO = IN_LANES / OUT_LANES;
  localparam int BEATS = IN_COLS / IN_LANES;
  localparam int XW    = $clog2(IN_COLS);
  localparam int YW    = $clog2(IN_ROWS);
  localparam int CW    = XW + 1;
  localparam int RW    = YW + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IW    = PIXEL_BIT_WIDTH * IN_LANES;
  localparam int OW    = PIXEL_BIT_WIDTH * OUT_LANES;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [IW-1:0] buf_data [2];
  logic [YW-1:0] buf_row  [2];
  logic [BW-1:0] buf_col  [2];
  logic [1:0]    buf_valid, buf_last;
  logic          rd_ptr, wr_ptr;
  logic [SW-1:0] sub;
  logic [BW-1:0] col_cnt, pos_col, col_nx;
  logic [YW-1:0] row_cnt, pos_row, row_nx;
  logic          in_done, pos_last;
  logic [CW-1:0] x0c, x0_mask, x0_new;
  logic [RW-1:0] y0c, y0_new;
  logic          in_hs, sof_hs;
  logic          unused_tuser;

  assign unused_tuser = ^s_axis_tuser;

  assign in_hs  = s_axis_tvalid && s_axis_tready;
  assign sof_hs = in_hs && s_axis_tuser[0];

  // Position of the beat being accepted; an SOF beat is always row 0, column beat 0.
  assign pos_col  = sof_hs ? '0 : col_cnt;
  assign pos_row  = sof_hs ? '0 : row_cnt;
  assign pos_last = (pos_row == YW'(IN_ROWS - 1)) && (pos_col == BW'(BEATS - 1));

  always_comb begin
    col_nx = pos_col + BW'(1);
    row_nx = pos_row;
    if (pos_col == BW'(BEATS - 1)) begin
      col_nx = '0;
      row_nx = (pos_row == YW'(IN_ROWS - 1)) ? '0 : pos_row + YW'(1);
    end
  end

  // Window origin: x aligned down to an output beat, both clamped so the window fits.
  assign x0_mask = {1'b0, crop_x0 & ~XW'(OUT_LANES - 1)};
  assign x0_new  = (x0_mask > CW'(IN_COLS - OUT_COLS)) ? CW'(IN_COLS - OUT_COLS) : x0_mask;
  assign y0_new  = ({1'b0, crop_y0} > RW'(IN_ROWS - OUT_ROWS)) ? RW'(IN_ROWS - OUT_ROWS)
                                                               : {1'b0, crop_y0};

  // Read side: the buffer at rd_ptr is walked one sub-beat at a time.
  logic          cur_valid, row_in, beat_hit, kept, eol, sub_last, advance, consume;
  logic [CW-1:0] cur_base, sub_col;
  logic [RW-1:0] cur_row;

  assign cur_valid = buf_valid[rd_ptr];
  assign cur_row   = {1'b0, buf_row[rd_ptr]};
  assign cur_base  = CW'(int'(buf_col[rd_ptr]) * IN_LANES);
  assign sub_col   = cur_base + CW'(int'(sub) * OUT_LANES);
  assign row_in    = (cur_row >= y0c) && (cur_row < y0c + RW'(OUT_ROWS));
  assign beat_hit  = row_in && (cur_base + CW'(IN_LANES) > x0c) && (cur_base < x0c + CW'(OUT_COLS));
  assign kept      = row_in && (sub_col >= x0c) && (sub_col < x0c + CW'(OUT_COLS));
  assign eol       = (sub_col + CW'(OUT_LANES - 1)) == (x0c + CW'(OUT_COLS - 1));
  assign sub_last  = (sub == SW'(RATIO - 1));
  assign advance   = cur_valid && (!kept || m_axis_tready);
  // A beat with no kept pixel is dropped in a single clock.
  assign consume   = cur_valid && (!beat_hit || (advance && sub_last));

  // Outputs come straight from the held buffer, so they stay stable under backpressure.
  assign m_axis_tvalid = cur_valid && kept;
  assign m_axis_tdata  = m_axis_tvalid ? buf_data[rd_ptr][int'(sub) * OW +: OW] : '0;
  assign m_axis_tlast  = m_axis_tvalid && eol;
  assign m_axis_tuser  = m_axis_tvalid ? {eol && (cur_row == y0c + RW'(OUT_ROWS - 1)),
                                          (sub_col == x0c) && (cur_row == y0c)} : 2'b00;

  // In RUN the write pointer's buffer is free whenever any buffer is free.
  // Input stops after the last beat of the frame until that beat is drained.
  assign s_axis_tready = !reset && ((state == IDLE) || (!in_done && !buf_valid[wr_ptr]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sof_hs) state_nx = RUN;
      RUN:     if (!sof_hs && consume && buf_last[rd_ptr]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_row[0]  <= '0;
      buf_row[1]  <= '0;
      buf_col[0]  <= '0;
      buf_col[1]  <= '0;
      buf_valid   <= '0;
      buf_last    <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      sub         <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      in_done     <= 1'b0;
      x0c         <= '0;
      y0c         <= '0;
    end else if (sof_hs) begin
      // New frame (also a mid-frame restart): drop everything, load the SOF beat into A.
      buf_data[0] <= s_axis_tdata;
      buf_row[0]  <= '0;
      buf_col[0]  <= '0;
      buf_valid   <= 2'b01;
      buf_last    <= {1'b0, pos_last};
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b1;
      sub         <= '0;
      col_cnt     <= col_nx;
      row_cnt     <= row_nx;
      in_done     <= pos_last;
      x0c         <= x0_new;
      y0c         <= y0_new;
    end else if (state == RUN) begin
      if (consume) begin
        buf_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= ~rd_ptr;
        sub               <= '0;
      end else if (advance) begin
        sub <= sub + SW'(1);
      end
      // Writes always target the free buffer, never the one being consumed.
      if (in_hs) begin
        buf_data[wr_ptr]  <= s_axis_tdata;
        buf_row[wr_ptr]   <= pos_row;
        buf_col[wr_ptr]   <= pos_col;
        buf_last[wr_ptr]  <= pos_last;
        buf_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= ~wr_ptr;
        col_cnt           <= col_nx;
        row_cnt           <= row_nx;
        in_done           <= in_done | pos_last;
      end
    end
  end

`ifdef SEQ_ERR_CNT_EN
  logic [15:0] err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (((state == RUN) && sof_hs) || ((state == IDLE) && in_hs && !s_axis_tuser[0])) begin
      if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_crop_serializer.sv
// tb/tb_crop_serializer.sv - scoreboard bench for crop_serializer
module tb_crop_serializer;
  logic         clk;
  logic         reset;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [99:0]  s_axis_tdata;
  logic [1:0]   s_axis_tuser;
  logic [4:0]   crop_x0;
  logic [4:0]   crop_y0;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [19:0]  m_axis_tdata;
  logic [1:0]   m_axis_tuser;
  logic         m_axis_tlast;
  logic [15:0]  err_count;

`ifdef SEQ_ERR_CNT_EN
  localparam int ERR_AFTER_ABORT = 1;
  localparam int ERR_AFTER_STRAY = 3;
`else
  localparam int ERR_AFTER_ABORT = 0;
  localparam int ERR_AFTER_STRAY = 0;
`endif

  crop_serializer dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .crop_x0(crop_x0), .crop_y0(crop_y0),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .err_count(err_count)
  );

  typedef struct packed {
    logic [19:0] d;
    logic [1:0]  u;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          skip_sofs = 0;
  int          out_cnt = 0;
  int          frame_beats = 0;
  logic [19:0] first_seen, last_seen;
  bit          bp_mode = 0;
  bit          abort_drv = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [9:0] pix(input int r, input int c);
    return 10'(r * 20 + c);
  endfunction

  function automatic logic [99:0] beat_data(input int r, input int cb);
    logic [99:0] d;
    for (int l = 0; l < 10; l++) d[l*10 +: 10] = pix(r, cb * 10 + l);
    return d;
  endfunction

  task automatic push_frame(input int x0, input int y0);
    int xc, yc;
    exp_t e;
    xc = x0 & ~1;
    if (xc > 10) xc = 10;
    yc = (y0 > 10) ? 10 : y0;
    for (int r = 0; r < 10; r++)
      for (int k = 0; k < 5; k++) begin
        e.d = {pix(yc + r, xc + 2*k + 1), pix(yc + r, xc + 2*k)};
        e.u = {(r == 9 && k == 4), (r == 0 && k == 0)};
        e.l = (k == 4);
        exp_q.push_back(e);
      end
  endtask

  task automatic drive_beats(input int nb, input bit rnd);
    bit hs;
    int wc;
    for (int b = 0; b < nb && !abort_drv; b++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin
        s_axis_tvalid = 0;
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1;
      s_axis_tuser  = (b == 0) ? 2'b01 : 2'b00;
      s_axis_tdata  = beat_data(b / 2, b % 2);
      hs = 0;
      wc = 0;
      while (!hs && !abort_drv) begin
        @(negedge clk);
        hs = s_axis_tready;
        @(posedge clk); #1;
        wc++;
        if (!hs && wc > 1000) begin
          chk("input_accept_timeout", 32'(wc), 32'd0);
          abort_drv = 1;
        end
      end
    end
    s_axis_tvalid = 0;
    s_axis_tuser  = 0;
  endtask

  task automatic run_frame(input int x0, input int y0, input bit rnd);
    crop_x0 = 5'(x0);
    crop_y0 = 5'(y0);
    frame_beats = 0;
    first_seen = '0;
    last_seen = '0;
    push_frame(x0, y0);
    drive_beats(40, rnd);
  endtask

  task automatic end_frame(input string tag, input logic [19:0] f, input logic [19:0] l);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_beats"}, 32'(frame_beats), 32'd50);
    chk({tag, "_first"}, 32'(first_seen), 32'(f));
    chk({tag, "_last"}, 32'(last_seen), 32'(l));
  endtask

  // Output readiness: constant 1, or alternating 1010 in backpressure mode.
  initial begin
    m_axis_tready = 1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
    end
  end

  // Monitor: stability under stall, then scoreboard compare on each handshake.
  initial begin
    bit          have_hold;
    logic [22:0] hold;
    exp_t        e;
    have_hold = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        have_hold = 0;
        continue;
      end
      if (have_hold) begin
        chk("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_payload", 32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(hold));
      end
      have_hold = m_axis_tvalid && !m_axis_tready;
      hold = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) begin
        out_cnt++;
        if (skip_sofs > 0 && m_axis_tuser[0]) skip_sofs--;
        if (skip_sofs > 0) begin
          chk("aborted_frame_no_eof", 32'(m_axis_tuser[1]), 32'd0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(m_axis_tdata), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(e));
          frame_beats++;
          if (m_axis_tuser[0]) first_seen = m_axis_tdata;
          if (m_axis_tuser[1]) last_seen = m_axis_tdata;
        end
      end
    end
  end

  initial begin
    int base;
    reset = 1;
    s_axis_tvalid = 0;
    s_axis_tuser = 0;
    s_axis_tdata = 0;
    crop_x0 = 0;
    crop_y0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tuser_tlast", 32'({m_axis_tuser, m_axis_tlast}), 32'd0);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset = 0;
    #1 chk("idle_s_tready", 32'(s_axis_tready), 32'd1);
    @(posedge clk); #1;

    run_frame(0, 0, 0);
    end_frame("full", {10'd1, 10'd0}, {10'd189, 10'd188});

    run_frame(7, 3, 0);
    end_frame("offset", {10'd67, 10'd66}, {10'd255, 10'd254});

    run_frame(19, 19, 0);
    end_frame("clamp", {10'd211, 10'd210}, {10'd399, 10'd398});

    bp_mode = 1;
    run_frame(7, 3, 1);
    end_frame("backpressure", {10'd67, 10'd66}, {10'd255, 10'd254});
    bp_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Frame 1 truncated by an SOF at its input beat 17.
    skip_sofs = 2;
    crop_x0 = 0;
    crop_y0 = 0;
    drive_beats(17, 0);
    run_frame(0, 0, 0);
    end_frame("abort", {10'd1, 10'd0}, {10'd189, 10'd188});
    chk("abort_err_count", 32'(err_count), 32'(ERR_AFTER_ABORT));

    // Asynchronous reset after 20 output beats.
    skip_sofs = 2;
    crop_x0 = 0;
    crop_y0 = 0;
    base = out_cnt;
    fork
      drive_beats(40, 0);
      begin
        int t = 0;
        while (out_cnt < base + 20 && t < 2000) begin
          @(negedge clk);
          t++;
        end
        chk("reset_wait_timeout", 32'(t >= 2000), 32'd0);
        #2 reset = 1;
        abort_drv = 1;
        #1;
        chk("async_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("async_rst_s_tready", 32'(s_axis_tready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 0;
      end
    join
    abort_drv = 0;
    @(posedge clk); #1;
    s_axis_tvalid = 1;
    s_axis_tuser = 2'b00;
    s_axis_tdata = beat_data(3, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    s_axis_tvalid = 0;
    @(negedge clk);
    chk("stray_dropped", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk); #1;
    run_frame(4, 5, 0);
    end_frame("after_reset", {10'd105, 10'd104}, {10'd293, 10'd292});
    chk("stray_err_count", 32'(err_count), 32'(ERR_AFTER_STRAY));

    repeat (20) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
